// File: rtl/stream_sink.sv
// Valid/ready/last frame sink: counts accepted beats, sums payload, flags frame-length errors.
// Optional LFSR-driven backpressure is built only when STREAM_SINK_STALL_EN is defined.
module stream_sink #(
    parameter int          DATA_W    = 8,
    parameter int          FRAME_LEN = 65536,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    input  logic              last_in,
    output logic              ready,
    output logic              stop_out,
    output logic [23:0]       beat_count,
    output logic [31:0]       checksum,
    output logic              err_early_last,
    output logic              err_missing_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_STALL,
        S_DONE
    } state_t;

    localparam logic [23:0] LAST_IDX = 24'(FRAME_LEN - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [31:0] sum_q, sum_d;
    logic        early_q, early_d;
    logic        miss_q, miss_d;

`ifdef STREAM_SINK_STALL_EN
    logic [15:0] lfsr_q;
    logic [5:0]  stall_q, stall_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            early_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            early_q <= early_d;
            miss_q  <= miss_d;
        end
    end

`ifdef STREAM_SINK_STALL_EN
    // Fibonacci LFSR, taps 16,14,13,11, free-running regardless of state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= LFSR_SEED;
            stall_q <= '0;
        end else begin
            lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            stall_q <= stall_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        early_d = early_q;
        miss_d  = miss_q;
`ifdef STREAM_SINK_STALL_EN
        stall_d = stall_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                    sum_d   = '0;
                    early_d = 1'b0;
                    miss_d  = 1'b0;
                end
            end
            S_RECV: begin
                if (valid) begin
                    cnt_d = cnt_q + 24'd1;
                    sum_d = sum_q + 32'(data_in);
                    // cnt_q is the index of this beat; the frame ends on last_in or the final index.
                    if (last_in || (cnt_q == LAST_IDX)) begin
                        state_d = S_DONE;
                        early_d = last_in && (cnt_q != LAST_IDX);
                        miss_d  = !last_in && (cnt_q == LAST_IDX);
                    end
`ifdef STREAM_SINK_STALL_EN
                    else if (lfsr_q[0]) begin
                        state_d = S_STALL;
                        stall_d = 6'd1 + {1'b0, lfsr_q[5:1]};
                    end
`endif
                end
            end
            S_STALL: begin
`ifdef STREAM_SINK_STALL_EN
                if (stall_q == 6'd1) begin
                    state_d = S_RECV;
                end else begin
                    stall_d = stall_q - 6'd1;
                end
`else
                state_d = S_RECV;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready            = (state_q == S_RECV);
    assign stop_out         = (state_q == S_DONE);
    assign beat_count       = cnt_q;
    assign checksum         = sum_q;
    assign err_early_last   = early_q;
    assign err_missing_last = miss_q;

endmodule
